// File: rtl/disp_scheduler_pkg.sv
// Shared display constants and FSM state type for the multiplexed 4-digit display.
package disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [3:0] DIG_EN0 = 4'b1110;
  localparam logic [3:0] DIG_EN1 = 4'b1101;
  localparam logic [3:0] DIG_EN2 = 4'b1011;
  localparam logic [3:0] DIG_EN3 = 4'b0111;
  localparam logic [3:0] DIG_OFF = 4'b1111;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  function automatic logic [3:0] dig_en(input logic [1:0] idx);
    case (idx)
      2'd0:    return DIG_EN0;
      2'd1:    return DIG_EN1;
      2'd2:    return DIG_EN2;
      default: return DIG_EN3;
    endcase
  endfunction

endpackage

// File: rtl/disp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 and wraps back to last itself.
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [1:0]         last,
  output logic               grant_valid,
  output logic [1:0]         grant_idx
);

  logic [3:0]  req_pad;
  logic [1:0]  c;
  int unsigned cand;

  assign req_pad = 4'(req);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = last;
    cand        = 0;
    c           = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (32'(last) + k) % NUM_SRC;
      c    = 2'(cand);
      if (!grant_valid && req_pad[c]) begin
        grant_valid = 1'b1;
        grant_idx   = c;
      end
    end
  end

endmodule

// File: rtl/disp_scheduler.sv
// Round-robin sharing of the 4-digit seven-segment display between result producers.
// Optional anti-ghosting blank at each digit slot start: define DISP_BLANK_EN.
module disp_scheduler #(
  parameter int unsigned NUM_SRC     = 4,
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned HOLD_FRAMES = 256,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [16*NUM_SRC-1:0]  src_data,
  output logic [NUM_SRC-1:0]     src_ack,
  output logic [3:0]             enable,
  output logic [3:0]             bcd,
  output logic                   dp,
  output logic [1:0]             active_src,
  output logic                   busy
);
  import disp_pkg::*;

  localparam int unsigned CNT_W  = $clog2(SCAN_DIV) + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES) + 1;
  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
`ifdef DISP_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [HOLD_W-1:0] hold;
  logic [15:0]       word;
  logic              tick, frame_end, blank;
  logic              grant_valid, do_grant, hold_inc;
  logic [1:0]        grant_idx;
  logic [3:0]        valid_pad;
  logic [63:0]       data_pad;

  assign tick      = (cnt == CNT_W'(SCAN_DIV - 1));
  assign frame_end = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign blank     = BLANK_ON && (cnt < CNT_W'(BLANK_CYC));
  assign valid_pad = 4'(src_valid);
  assign data_pad  = 64'(src_data);
  assign busy      = (state == SHOW);

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .req         (src_valid),
    .last        (active_src),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // All decisions happen only on frame_end, so the shown word never tears mid-scan.
  always_comb begin
    state_d  = state;
    do_grant = 1'b0;
    hold_inc = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            do_grant = 1'b1;
            state_d  = SHOW;
          end
        end
        SHOW: begin
          if (hold == HOLD_W'(HOLD_FRAMES - 1) || !valid_pad[active_src]) begin
            if (grant_valid) do_grant = 1'b1;
            else             state_d  = IDLE;
          end else begin
            hold_inc = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      hold       <= '0;
      word       <= '0;
      active_src <= '0;
      src_ack    <= '0;
      enable     <= DIG_OFF;
      bcd        <= '0;
      dp         <= 1'b1;
    end else begin
      cnt     <= tick ? '0 : cnt + 1'b1;
      src_ack <= '0;
      if (tick) idx <= idx + 1'b1;
      if (do_grant) begin
        word       <= data_pad[{grant_idx, 4'b0000} +: 16];
        src_ack    <= NUM_SRC'(4'b0001 << grant_idx);
        active_src <= grant_idx;
        hold       <= '0;
      end else if (hold_inc) begin
        hold <= hold + 1'b1;
      end
      enable <= (state == SHOW && !blank) ? dig_en(idx) : DIG_OFF;
      bcd    <= word[{idx, 2'b00} +: 4];
      dp     <= !(state == SHOW && idx == active_src);
    end
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Self-checking bench for disp_scheduler: vector table, directed corner sequences, random run vs model.
module tb_disp_scheduler;

  localparam int unsigned NS = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned HF = 2;
  localparam int unsigned BC = 2;
  localparam int unsigned FR = 4 * SD;
`ifdef DISP_BLANK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_valid;
  logic [63:0] src_data;
  logic [3:0]  src_ack;
  logic [3:0]  enable;
  logic [3:0]  bcd;
  logic        dp;
  logic [1:0]  active_src;
  logic        busy;

  always #5 clk = ~clk;

  disp_scheduler #(
    .NUM_SRC     (NS),
    .SCAN_DIV    (SD),
    .HOLD_FRAMES (HF),
    .BLANK_CYC   (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ack    (src_ack),
    .enable     (enable),
    .bcd        (bcd),
    .dp         (dp),
    .active_src (active_src),
    .busy       (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle counter since reset gives digit/phase arithmetically;
  // arbitration decided at each frame end from a rotating candidate list.
  int unsigned m_n, m_act, m_hold, m_dig, m_ph;
  bit          m_show, m_fe, m_rearb, m_found;
  logic [15:0] m_word;
  int unsigned cand[$];
  logic [3:0]  e_en, e_bcd, e_ack;
  logic        e_dp, e_busy;
  logic [1:0]  e_act;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_n = 0; m_act = 0; m_hold = 0; m_show = 1'b0; m_word = '0;
      e_en = 4'hF; e_bcd = 4'h0; e_dp = 1'b1; e_act = 2'd0; e_ack = 4'h0; e_busy = 1'b0;
      chk_en = 1'b1;
    end else begin
      m_dig = (m_n / SD) % 4;
      m_ph  = m_n % SD;
      m_fe  = (m_n % FR) == FR - 1;
      e_en  = (m_show && !(BL && m_ph < BC)) ? ~(4'b0001 << m_dig) : 4'hF;
      e_bcd = 4'((m_word >> (4 * m_dig)) & 16'hF);
      e_dp  = !(m_show && m_dig == m_act);
      e_ack = 4'h0;
      if (m_fe) begin
        m_rearb = !m_show || (m_hold + 1 >= HF) || !src_valid[m_act];
        if (!m_rearb) begin
          m_hold++;
        end else begin
          cand = {};
          for (int unsigned k = 1; k <= NS; k++) cand.push_back((m_act + k) % NS);
          m_found = 1'b0;
          foreach (cand[j]) begin
            if (!m_found && src_valid[cand[j]]) begin
              m_found = 1'b1;
              m_act   = cand[j];
            end
          end
          if (m_found) begin
            m_word = src_data[16*m_act +: 16];
            e_ack  = 4'(1 << m_act);
            m_hold = 0;
            m_show = 1'b1;
          end else begin
            m_show = 1'b0;
          end
        end
      end
      e_act  = 2'(m_act);
      e_busy = m_show;
      m_n++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_enable", enable, e_en);
      check("model_bcd", bcd, e_bcd);
      check("model_dp", dp, e_dp);
      check("model_active", active_src, e_act);
      check("model_ack", src_ack, e_ack);
      check("model_busy", busy, e_busy);
    end
  end

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] data;
    int          frames;
    logic [1:0]  exp_act;
    logic        exp_busy;
    int          exp_acks;
    bit          dark;
  } vec_t;

  vec_t tbl[8];
  int   acks, lit;
  int   d;
  logic [3:0] x_en;

  initial begin
    tbl[0] = '{4'b0000, 64'h0,                   6, 2'd0, 1'b0, 0, 1'b1};
    tbl[1] = '{4'b0001, 64'h0000_0000_0000_1234, 3, 2'd0, 1'b1, 2, 1'b0};
    tbl[2] = '{4'b0101, 64'h0000_3333_0000_1111, 4, 2'd0, 1'b1, 2, 1'b0};
    tbl[3] = '{4'b0100, 64'h0000_3333_0000_1111, 2, 2'd2, 1'b1, 1, 1'b0};
    tbl[4] = '{4'b0000, 64'h0000_3333_0000_1111, 2, 2'd2, 1'b0, 0, 1'b0};
    tbl[5] = '{4'b1010, 64'h5678_0000_abcd_0000, 2, 2'd3, 1'b1, 1, 1'b0};
    tbl[6] = '{4'b1010, 64'h5678_0000_abcd_0000, 2, 2'd1, 1'b1, 1, 1'b0};
    tbl[7] = '{4'b1111, 64'h5678_3333_abcd_1111, 4, 2'd3, 1'b1, 2, 1'b0};

    rst_n = 1'b0; src_valid = '0; src_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      src_valid = tbl[i].valid;
      src_data  = tbl[i].data;
      acks = 0; lit = 0;
      repeat (tbl[i].frames * FR) begin
        @(negedge clk);
        if (src_ack != 4'h0) acks++;
        if (enable != 4'hF) lit++;
      end
      check($sformatf("tbl%0d_active", i), active_src, tbl[i].exp_act);
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
      check($sformatf("tbl%0d_acks", i), acks, tbl[i].exp_acks);
      if (tbl[i].dark) check($sformatf("tbl%0d_dark", i), lit, 0);
    end

    // Grant of 1234 to source 0, then a full scan; source data changes mid-frame.
    src_valid = 4'b0001;
    src_data  = 64'h5678_3333_abcd_1234;
    repeat (FR) @(negedge clk);
    check("h1_grant_ack", src_ack, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      d    = i / 4;
      x_en = (BL && (i % 4) < BC) ? 4'hF : ~(4'b0001 << d);
      check($sformatf("h1_enable%0d", i), enable, x_en);
      check($sformatf("h1_bcd%0d", i), bcd, 4 - d);
      check($sformatf("h1_dp%0d", i), dp, (d != 0));
      if (i == 7) src_data[15:0] = 16'h9999;
    end

    // Early release: source 1 drops valid mid-frame while hold has not expired.
    src_valid = 4'b0011;
    src_data[31:16] = 16'h4321;
    repeat (FR) @(negedge clk);
    check("h2_grant1_active", active_src, 2'd1);
    check("h2_grant1_ack", src_ack, 4'b0010);
    repeat (FR / 2) @(negedge clk);
    check("h2_mid_active", active_src, 2'd1);
    src_valid = 4'b0001;
    repeat (FR / 2) @(negedge clk);
    check("h2_release_active", active_src, 2'd0);
    check("h2_release_ack", src_ack, 4'b0001);
    check("h2_release_busy", busy, 1'b1);

    // Reset mid-scan.
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("h3_rst_enable", enable, 4'hF);
    check("h3_rst_bcd", bcd, 4'h0);
    check("h3_rst_dp", dp, 1'b1);
    check("h3_rst_active", active_src, 2'd0);
    check("h3_rst_ack", src_ack, 4'h0);
    check("h3_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    repeat (2000) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 7) == 0) src_valid = 4'($urandom);
      if ($urandom_range(0, 3) == 0) src_data = {$urandom, $urandom};
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
